// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and data requesters, the arbiter and the shared memory.
// The arbiter takes the slave modport; the requester/memory side takes the master modport.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory; mem_req one cycle after accept, rvalid one cycle after mem_ack.
// One transaction in flight: both readys low while busy; data has priority, bounded by a fetch-starvation streak.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          owner;
  logic          idle;
  logic          fetch_turn;
  logic          fetch_win;
  logic          data_win;

  assign idle       = (state == IDLE);
  assign fetch_turn = (streak == STREAK_MAX);
  assign fetch_win  = idle && bus.if_req && (!bus.d_req || fetch_turn);
  assign data_win   = idle && bus.d_req && !(bus.if_req && fetch_turn);

  assign bus.if_ready = fetch_win;
  assign bus.d_ready  = data_win;
  assign bus.mem_req  = (state == BUSY);
  assign bus.busy     = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      streak        <= '0;
      owner         <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_win) begin
            state         <= BUSY;
            owner         <= 1'b0;
            streak        <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
          end else if (data_win) begin
            state         <= BUSY;
            owner         <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_wstrb <= bus.d_wstrb;
            // Only grants that make fetch wait count toward its starvation bound.
            if (bus.if_req && !fetch_turn)
              streak <= streak + SW'(1);
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            state <= IDLE;
            if (owner) begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= bus.mem_rdata;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
